div_4: RTL and testbench

Sequential shift-subtract (restoring) divider: the inverse datapath of the 4-bit shift-add multiplier. It takes a 2N-bit dividend and an N-bit divisor on `init` and produces a 2N-bit quotient and an N-bit remainder after one iteration per dividend bit. It sits beside the multiplier in the arithmetic block and uses the same `init`/`done` handshake, so one controller can drive either unit.

---
 rtl/div_4.sv | 116 +++++++++++
 tb/tb_div_4.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_4.sv
// rtl/div_4.sv - restoring shift-subtract divider, 2N-bit dividend by N-bit divisor, init/done handshake
// Build option DIV_ZERO_DET_EN: a zero divisor completes one cycle after start with err=1.
module div_4 #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic [2*N-1:0] A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] q,
   output logic [N-1:0]   r,
   output logic           done,
   output logic           err
);
   localparam int CW = (2*N > 1) ? $clog2(2*N) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(2*N-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [2*N-1:0] dvd;
   logic [2*N-1:0] quo;
   logic [N-1:0]   dvs;
   logic [N:0]     pr;
   logic [CW-1:0]  cnt;

   logic [N:0]     trial;
   logic           fits;
   logic [N:0]     pr_nxt;
   logic [2*N-1:0] quo_nxt;

   // One restoring step: bring down the next dividend bit and try the subtraction.
   always_comb begin
      trial   = {pr[N-1:0], dvd[2*N-1]};
      fits    = (trial >= {1'b0, dvs});
      pr_nxt  = fits ? (trial - {1'b0, dvs}) : trial;
      quo_nxt = {quo[2*N-2:0], fits};
   end

`ifdef DIV_ZERO_DET_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dvd   <= '0;
         dvs   <= '0;
         pr    <= '0;
         quo   <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         done  <= 1'b0;
`ifdef DIV_ZERO_DET_EN
         err_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (init) begin
                  dvd   <= A;
                  dvs   <= B;
                  pr    <= '0;
                  quo   <= '0;
                  cnt   <= CNT_LOAD;
                  q     <= '0;
                  r     <= '0;
`ifdef DIV_ZERO_DET_EN
                  err_q <= 1'b0;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
`ifdef DIV_ZERO_DET_EN
               // Dividend register is still unshifted here, so its low bits are A[N-1:0].
               if (dvs == '0) begin
                  q     <= '1;
                  r     <= dvd[N-1:0];
                  err_q <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else
`endif
               begin
                  dvd <= dvd << 1;
                  pr  <= pr_nxt;
                  quo <= quo_nxt;
                  if (cnt == '0) begin
                     q     <= quo_nxt;
                     r     <= pr_nxt[N-1:0];
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_4.sv
// tb/tb_div_4.sv - directed-vector bench for div_4 (N=4); expectations follow DIV_ZERO_DET_EN
module tb_div_4;
   localparam int N = 4;
`ifdef DIV_ZERO_DET_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       init;
   logic [7:0] A;
   logic [3:0] B;
   logic [7:0] q;
   logic [3:0] r;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   div_4 #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .init (init),
      .A    (A),
      .B    (B),
      .q    (q),
      .r    (r),
      .done (done),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called just after a posedge with the DUT in IDLE; the next posedge is the start edge.
   task automatic start(input logic [7:0] a, input logic [3:0] b);
      A = a;
      B = b;
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
   endtask

   task automatic wait_done(input bit disturb, output int lat);
      lat = 0;
      while (lat <= 20) begin
         if (disturb) begin
            init = 1'($urandom);
            A = 8'($urandom);
            B = 4'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
      init = 1'b0;
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input int elat, input int eq, input int er, input int eerr);
      int lat;
      start(a, b);
      wait_done(1'b0, lat);
      check({tag, "_lat"}, lat, elat);
      check({tag, "_q"}, q, eq);
      check({tag, "_r"}, r, er);
      check({tag, "_err"}, err, eerr);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int lat;
      int n;
      int dk[3];

      rst = 1'b1;
      init = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_q", q, 0);
      check("rst_r", r, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op("d200_7", 8'd200, 4'd7, 8, 28, 4, 0);
      run_op("d255_1", 8'd255, 4'd1, 8, 255, 0, 0);
      run_op("d5_9", 8'd5, 4'd9, 8, 0, 5, 0);
      run_op("d0_15", 8'd0, 4'd15, 8, 0, 0, 0);
      run_op("div0", 8'hA7, 4'd0, ZD ? 1 : 8, 8'hFF, 4'h7, ZD ? 1 : 0);

      // Inputs and init scrambled while the operation runs.
      start(8'd100, 4'd3);
      wait_done(1'b1, lat);
      check("dist_lat", lat, 8);
      check("dist_q", q, 33);
      check("dist_r", r, 1);
      count_done(12, n);
      check("dist_single_done", n, 0);
      check("dist_q_hold", q, 33);

      // Asynchronous reset mid-RUN.
      start(8'd200, 4'd7);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mrst_q", q, 0);
      check("mrst_r", r, 0);
      check("mrst_done", done, 0);
      check("mrst_err", err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      count_done(12, n);
      check("mrst_no_done", n, 0);
      run_op("d9_2", 8'd9, 4'd2, 8, 4, 1, 0);

      // init held high: starts every 2N+2 edges.
      A = 8'd50;
      B = 4'd6;
      init = 1'b1;
      n = 0;
      dk = '{-1, -1, -1};
      for (int k = 0; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (n < 3) dk[n] = k;
            n++;
            check("hold_q", q, 8);
            check("hold_r", r, 2);
         end
      end
      init = 1'b0;
      check("hold_ndone", n, 3);
      check("hold_done0", dk[0], 8);
      check("hold_done1", dk[1], 18);
      check("hold_done2", dk[2], 28);
      wait_done(1'b0, lat);
      check("hold_tail_lat", lat, 8);
      @(posedge clk);
      #1;

      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            start(8'(a), 4'(b));
            wait_done(1'b0, lat);
            check("sweep_lat", lat, 8);
            check("sweep_qbr", int'(q) * b + int'(r), a);
            check("sweep_r_lt_b", (int'(r) < b) ? 1 : 0, 1);
            @(posedge clk);
            #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
